game_controller: RTL and testbench

//   Round/level sequencer for the road-crossing game. Consumes the collision flag

---
 rtl/game_controller.sv | 151 +++++++++++++++
 tb/tb_game_controller.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// Round/level sequencer for the road-crossing game: respawn timing, level/speed, lives, game over.
// Optional feature macro GAME_LIVES_EN enables the lives counter and the GAME_OVER state.
module game_controller #(
    parameter int NUM_LIVES      = 3,
    parameter int MAX_LEVEL      = 9,
    parameter int RESPAWN_CYCLES = 2,
    parameter int GOAL_H         = 560
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       collision,
    input  logic [9:0] player_h,
    output logic [9:0] level,
    output logic [3:0] bar_speed,
    output logic [2:0] lives,
    output logic       reset_player,
    output logic       level_up,
    output logic       game_over,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESPAWN   = 3'd1,
        PLAY      = 3'd2,
        LEVEL_UP  = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam logic [9:0] MAX_LVL  = 10'(MAX_LEVEL);
    localparam logic [9:0] GOAL     = 10'(GOAL_H);
    localparam logic [7:0] RSP_INIT = 8'(RESPAWN_CYCLES);

    state_t     st;
    logic [7:0] cnt;
    logic [9:0] level_inc;

    // Speed tracks the level being written so both registers change together.
    function automatic logic [3:0] speed_of(input logic [9:0] l);
        logic [10:0] s;
        s = {1'b0, l} + 11'd1;
        return (s > 11'd15) ? 4'd15 : s[3:0];
    endfunction

    assign level_inc = (level == MAX_LVL) ? level : level + 10'd1;
    assign state     = st;

`ifdef GAME_LIVES_EN
    localparam logic [2:0] LIVES_INIT = 3'(NUM_LIVES);
    logic [2:0] lives_q;
    logic       game_over_q;
    assign lives     = lives_q;
    assign game_over = game_over_q;
`else
    assign lives     = 3'd0;
    assign game_over = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            st           <= IDLE;
            level        <= 10'd0;
            bar_speed    <= speed_of(10'd0);
            reset_player <= 1'b1;
            level_up     <= 1'b0;
            cnt          <= 8'd0;
`ifdef GAME_LIVES_EN
            lives_q      <= LIVES_INIT;
            game_over_q  <= 1'b0;
`endif
        end else begin
            level_up <= 1'b0;
            case (st)
                IDLE: begin
                    reset_player <= 1'b1;
                    if (start) begin
                        st  <= RESPAWN;
                        cnt <= RSP_INIT;
                    end
                end

                RESPAWN: begin
                    reset_player <= 1'b1;
                    cnt          <= cnt - 8'd1;
                    if (cnt <= 8'd1) begin
                        st           <= PLAY;
                        reset_player <= 1'b0;
                    end
                end

                PLAY: begin
                    reset_player <= 1'b0;
                    if (collision) begin
`ifdef GAME_LIVES_EN
                        if (lives_q <= 3'd1) begin
                            lives_q      <= 3'd0;
                            st           <= GAME_OVER;
                            game_over_q  <= 1'b1;
                            reset_player <= 1'b1;
                        end else begin
                            lives_q      <= lives_q - 3'd1;
                            st           <= RESPAWN;
                            cnt          <= RSP_INIT;
                            reset_player <= 1'b1;
                        end
`else
                        // Without lives, a hit just restarts the game from level 0.
                        level        <= 10'd0;
                        bar_speed    <= speed_of(10'd0);
                        st           <= RESPAWN;
                        cnt          <= RSP_INIT;
                        reset_player <= 1'b1;
`endif
                    end else if (player_h >= GOAL) begin
                        st       <= LEVEL_UP;
                        level_up <= 1'b1;
                    end
                end

                LEVEL_UP: begin
                    level        <= level_inc;
                    bar_speed    <= speed_of(level_inc);
                    st           <= RESPAWN;
                    cnt          <= RSP_INIT;
                    reset_player <= 1'b1;
                end

                GAME_OVER: begin
                    reset_player <= 1'b1;
                    if (start) begin
                        level     <= 10'd0;
                        bar_speed <= speed_of(10'd0);
                        st        <= RESPAWN;
                        cnt       <= RSP_INIT;
`ifdef GAME_LIVES_EN
                        lives_q     <= LIVES_INIT;
                        game_over_q <= 1'b0;
`endif
                    end
                end

                default: begin
                    st           <= IDLE;
                    reset_player <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller; expected values are hand-derived and
// follow whichever lives configuration (GAME_LIVES_EN) the build selects.
module tb_game_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       collision;
    logic [9:0] player_h;
    logic [9:0] level;
    logic [3:0] bar_speed;
    logic [2:0] lives;
    logic       reset_player;
    logic       level_up;
    logic       game_over;
    logic [2:0] state;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_lvl;

    game_controller dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .collision    (collision),
        .player_h     (player_h),
        .level        (level),
        .bar_speed    (bar_speed),
        .lives        (lives),
        .reset_player (reset_player),
        .level_up     (level_up),
        .game_over    (game_over),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int speed(input int l);
        return (l + 1 > 15) ? 15 : l + 1;
    endfunction

    task automatic wait_play(input string tag);
        for (int i = 0; i < 8 && state != 3'd2; i++) step();
        chk(tag, state, 2);
    endtask

    // Reach goal from PLAY, check the pulse, the new level/speed and the respawn.
    task automatic goal_once();
        player_h = 10'd560;
        step();
        chk("lu_state", state, 3);
        chk("lu_pulse", level_up, 1);
        chk("lu_lvl_hold", level, exp_lvl);
        player_h = 10'd0;
        exp_lvl  = (exp_lvl == 9) ? 9 : exp_lvl + 1;
        step();
        chk("lu_pulse_end", level_up, 0);
        chk("lu_level", level, exp_lvl);
        chk("lu_speed", bar_speed, speed(exp_lvl));
        chk("lu_respawn", state, 1);
        wait_play("lu_play");
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; collision = 1'b0; player_h = 10'd0;
        step();
        chk("rst_state", state, 0);
        chk("rst_level", level, 0);
        chk("rst_speed", bar_speed, 1);
        chk("rst_rp", reset_player, 1);
        chk("rst_go", game_over, 0);
        chk("rst_lu", level_up, 0);
`ifdef GAME_LIVES_EN
        chk("rst_lives", lives, 3);
`else
        chk("rst_lives", lives, 0);
`endif
        reset = 1'b1;
        step();
        chk("idle_hold", state, 0);

        // start -> exactly two respawn cycles
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rsp1_state", state, 1);
        chk("rsp1_rp", reset_player, 1);
        step();
        chk("rsp2_state", state, 1);
        chk("rsp2_rp", reset_player, 1);
        step();
        chk("play_state", state, 2);
        chk("play_rp", reset_player, 0);

        exp_lvl = 0;
        goal_once();

        // collision wins over the goal in the same cycle
        collision = 1'b1; player_h = 10'd600;
        step();
        collision = 1'b0; player_h = 10'd0;
        chk("cg_state", state, 1);
        chk("cg_lu", level_up, 0);
`ifdef GAME_LIVES_EN
        chk("cg_lives", lives, 2);
        chk("cg_level", level, 1);
        wait_play("cg_play");
        collision = 1'b1;
        step();
        collision = 1'b0;
        chk("hit2_lives", lives, 1);
        chk("hit2_state", state, 1);
        wait_play("hit2_play");
        collision = 1'b1;
        step();
        collision = 1'b0;
        chk("hit3_lives", lives, 0);
        chk("hit3_state", state, 4);
        chk("hit3_go", game_over, 1);
        chk("hit3_rp", reset_player, 1);
        step();
        chk("go_hold", state, 4);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rs_state", state, 1);
        chk("rs_lives", lives, 3);
        chk("rs_level", level, 0);
        chk("rs_go", game_over, 0);
        exp_lvl = 0;
        wait_play("rs_play");
        while (exp_lvl < 9) goal_once();
`else
        chk("cg_lives", lives, 0);
        chk("cg_level", level, 0);
        chk("cg_speed", bar_speed, 1);
        exp_lvl = 0;
        wait_play("cg_play");
        while (exp_lvl < 5) goal_once();
        collision = 1'b1;
        step();
        collision = 1'b0;
        chk("l5_hit_level", level, 0);
        chk("l5_hit_go", game_over, 0);
        chk("l5_hit_state", state, 1);
        exp_lvl = 0;
        wait_play("l5_play");
        while (exp_lvl < 9) goal_once();
`endif

        // goal at max level: level saturates, pulse still fires
        player_h = 10'd560;
        step();
        chk("max_lu", level_up, 1);
        player_h = 10'd0;
        step();
        chk("max_level", level, 9);
        chk("max_speed", bar_speed, 10);
        chk("max_respawn", state, 1);

        // reset during respawn
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rr_state", state, 0);
        chk("rr_level", level, 0);
        chk("rr_rp", reset_player, 1);
        step();
        chk("rr_idle", state, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
